// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: game FSM, lives, BCD score, pause timer and ball freeze.
// Optional high-score register is enabled by defining PONG_HI_SCORE_EN.
module pong_game_ctrl #(
   parameter int LIVES      = 3,
   parameter int WAIT_TICKS = 120
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       refr_tick,
   input  logic [3:0] btn,
   input  logic       hit,
   input  logic       miss,
   output logic       gra_still,
   output logic [1:0] state_out,
   output logic [2:0] lives,
   output logic [7:0] score,
   output logic [7:0] hi_score,
   output logic       timer_busy
);

   // state   | meaning
   // NEWGAME | idle, ball frozen, waiting for a start press
   // PLAY    | ball moving, hit/miss events counted
   // NEWBALL | ball frozen after a miss, press accepted once pause expires
   // OVER    | final result shown, returns to NEWGAME when pause expires
   typedef enum logic [1:0] {
      S_NEWGAME = 2'b00,
      S_PLAY    = 2'b01,
      S_NEWBALL = 2'b10,
      S_OVER    = 2'b11
   } state_t;

   localparam logic [2:0] LIVES_INIT = 3'(LIVES);
   localparam logic [7:0] WAIT_INIT  = 8'(WAIT_TICKS);

   state_t     state, state_nxt;
   logic       btn_any, btn_any_d, press;
   logic [7:0] timer, timer_nxt;
   logic       timer_load;
   logic [2:0] lives_nxt;
   logic [7:0] score_nxt;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         if (v[7:4] == 4'd9) r = 8'h00;
         else                r = {v[7:4] + 4'd1, 4'h0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   assign btn_any    = |btn;
   assign press      = btn_any & ~btn_any_d;
   assign timer_busy = (timer != 8'd0);
   assign state_out  = state;

   always_comb begin
      state_nxt  = state;
      lives_nxt  = lives;
      score_nxt  = score;
      timer_load = 1'b0;
      case (state)
         S_NEWGAME: begin
            if (press) begin
               state_nxt = S_PLAY;
               score_nxt = 8'h00;
               lives_nxt = LIVES_INIT;
            end
         end
         S_PLAY: begin
            // a miss wins over a simultaneous hit; that hit is dropped
            if (miss) begin
               timer_load = 1'b1;
               if (lives <= 3'd1) begin
                  lives_nxt = 3'd0;
                  state_nxt = S_OVER;
               end else begin
                  lives_nxt = lives - 3'd1;
                  state_nxt = S_NEWBALL;
               end
            end else if (hit) begin
               score_nxt = bcd_inc(score);
            end
         end
         S_NEWBALL: begin
            if (press && !timer_busy) state_nxt = S_PLAY;
         end
         S_OVER: begin
            if (!timer_busy) state_nxt = S_NEWGAME;
         end
         default: state_nxt = S_NEWGAME;
      endcase

      if (timer_load)                  timer_nxt = WAIT_INIT;
      else if (refr_tick && timer_busy) timer_nxt = timer - 8'd1;
      else                             timer_nxt = timer;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_NEWGAME;
         gra_still <= 1'b1;
         lives     <= LIVES_INIT;
         score     <= 8'h00;
         timer     <= 8'd0;
         btn_any_d <= 1'b0;
      end else begin
         state     <= state_nxt;
         gra_still <= (state_nxt != S_PLAY);
         lives     <= lives_nxt;
         score     <= score_nxt;
         timer     <= timer_nxt;
         btn_any_d <= btn_any;
      end
   end

`ifdef PONG_HI_SCORE_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi_score <= 8'h00;
      end else if (state == S_PLAY && state_nxt == S_OVER && score > hi_score) begin
         hi_score <= score;
      end
   end
`else
   assign hi_score = 8'h00;
`endif

endmodule
